// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: START / byte WRITE / byte READ / STOP on open-drain SCL/SDA.
// Latency: START/STOP 4*CLK_DIV+2 cycles, WRITE/READ 9*(4*CLK_DIV+2), illegal command 1 cycle; longer under clock stretching.
// Backpressure: o_cmd_ready low while a command runs; valid without ready is ignored, never queued.
//
// Ports:
//   i_sysclk, i_reset_n         system clock, asynchronous active-low reset
//   scl_pin, sda_pin            open-drain pads (pulled up externally)
//   i_cmd_valid / o_cmd_ready   command handshake; i_cmd 1=START 2=WRITE 3=READ 4=STOP
//   i_wdata, i_ack_out          WRITE byte and READ ack bit, captured at accept
//   o_rdata, o_rx_ack           READ byte and WRITE ack bit, held until next update
//   o_done, o_err               completion pulse, error pulse for illegal commands
//   o_busy                      bus owned between START and STOP completion
module i2c_master_ctrl #(
    parameter int CLK_DIV = 250
) (
    input  logic       i_sysclk,
    input  logic       i_reset_n,
    inout  wire        scl_pin,
    inout  wire        sda_pin,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [2:0] i_cmd,
    input  logic [7:0] i_wdata,
    input  logic       i_ack_out,
    output logic [7:0] o_rdata,
    output logic       o_rx_ack,
    output logic       o_done,
    output logic       o_err,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    localparam logic [2:0]  CMD_START = 3'd1;
    localparam logic [2:0]  CMD_WRITE = 3'd2;
    localparam logic [2:0]  CMD_READ  = 3'd3;
    localparam logic [2:0]  CMD_STOP  = 3'd4;

    localparam logic [1:0]  PH_A = 2'd0;
    localparam logic [1:0]  PH_B = 2'd1;
    localparam logic [1:0]  PH_C = 2'd2;
    localparam logic [1:0]  PH_D = 2'd3;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_t      state;
    logic [1:0]  phase;
    logic [3:0]  bit_cnt;
    logic [15:0] div_cnt;
    logic [1:0]  settle_cnt;
    logic [7:0]  tx_byte;
    logic [7:0]  rx_shift;
    logic        ack_out_q;
    logic        scl_oen;
    logic        sda_oen;

    logic        scl_s1, scl_s2;
    logic        sda_s1, sda_s2;

    logic        cmd_legal;
    state_t      cmd_state;
    logic        div_last;
    logic        settle_done;
    logic        phase_end;
    logic        last_bit;

    // Open-drain pads: only ever drive low, otherwise release to the pullup.
    assign scl_pin = scl_oen ? 1'bz : 1'b0;
    assign sda_pin = sda_oen ? 1'bz : 1'b0;

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl_pin;
            scl_s2 <= scl_s1;
            sda_s1 <= sda_pin;
            sda_s2 <= sda_s1;
        end
    end

    always_comb begin
        cmd_legal = 1'b0;
        cmd_state = ST_IDLE;
        case (i_cmd)
            CMD_START: begin cmd_legal = 1'b1;   cmd_state = ST_START; end
            CMD_WRITE: begin cmd_legal = o_busy; cmd_state = ST_WRITE; end
            CMD_READ:  begin cmd_legal = o_busy; cmd_state = ST_READ;  end
            CMD_STOP:  begin cmd_legal = o_busy; cmd_state = ST_STOP;  end
            default:   begin cmd_legal = 1'b0;   cmd_state = ST_IDLE;  end
        endcase
    end

    // Phase B ignores the synchronized SCL for its first two cycles so that a
    // line that was already high (START from an idle bus) and a line being
    // released both give the same B length; the quarter count then runs only
    // while SCL reads high, which is what makes slave stretching work.
    assign div_last    = (div_cnt == DIV_LAST);
    assign settle_done = (settle_cnt == 2'd2);
    assign last_bit    = ((state == ST_WRITE) || (state == ST_READ)) ? (bit_cnt == 4'd8) : 1'b1;

    always_comb begin
        phase_end = div_last;
        if (phase == PH_B) begin
            phase_end = settle_done && scl_s2 && div_last;
        end
    end

    // SDA value to present in phase A of a given bit.
    function automatic logic sda_phase_a(input state_t st, input logic [3:0] b,
                                         input logic [7:0] tx, input logic ack);
        logic v;
        v = 1'b1;
        case (st)
            ST_START: v = 1'b1;
            ST_WRITE: v = (b == 4'd8) ? 1'b1 : tx[3'd7 - b[2:0]];
            ST_READ:  v = (b == 4'd8) ? ack : 1'b1;
            ST_STOP:  v = 1'b0;
            default:  v = 1'b1;
        endcase
        return v;
    endfunction

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            phase       <= PH_A;
            bit_cnt     <= 4'd0;
            div_cnt     <= 16'd0;
            settle_cnt  <= 2'd0;
            tx_byte     <= 8'h00;
            rx_shift    <= 8'h00;
            ack_out_q   <= 1'b1;
            scl_oen     <= 1'b1;
            sda_oen     <= 1'b1;
            o_cmd_ready <= 1'b1;
            o_rdata     <= 8'h00;
            o_rx_ack    <= 1'b1;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_cmd_valid && o_cmd_ready) begin
                        if (!cmd_legal) begin
                            // Rejected in place: no state, pad or data change.
                            o_done <= 1'b1;
                            o_err  <= 1'b1;
                        end else begin
                            o_cmd_ready <= 1'b0;
                            state       <= cmd_state;
                            phase       <= PH_A;
                            bit_cnt     <= 4'd0;
                            div_cnt     <= 16'd0;
                            settle_cnt  <= 2'd0;
                            tx_byte     <= i_wdata;
                            ack_out_q   <= i_ack_out;
                            sda_oen     <= sda_phase_a(cmd_state, 4'd0, i_wdata, i_ack_out);
                        end
                    end
                end
                default: begin
                    if (phase_end) begin
                        div_cnt <= 16'd0;
                    end else if ((phase != PH_B) || (settle_done && scl_s2)) begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                    if ((phase == PH_B) && !settle_done) begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end

                    if (phase_end) begin
                        case (phase)
                            PH_A: begin
                                phase      <= PH_B;
                                scl_oen    <= 1'b1;
                                settle_cnt <= 2'd0;
                            end
                            PH_B: begin
                                phase <= PH_C;
                                // SDA edges with SCL high mark START (fall) and STOP (rise).
                                if (state == ST_START) begin
                                    sda_oen <= 1'b0;
                                end else if (state == ST_STOP) begin
                                    sda_oen <= 1'b1;
                                end
                            end
                            PH_C: begin
                                phase <= PH_D;
                                if (state != ST_STOP) begin
                                    scl_oen <= 1'b0;
                                end
                                if ((state == ST_WRITE) && (bit_cnt == 4'd8)) begin
                                    o_rx_ack <= sda_s2;
                                end
                                if ((state == ST_READ) && (bit_cnt != 4'd8)) begin
                                    rx_shift <= {rx_shift[6:0], sda_s2};
                                end
                            end
                            default: begin
                                if (last_bit) begin
                                    state       <= ST_IDLE;
                                    o_cmd_ready <= 1'b1;
                                    o_done      <= 1'b1;
                                    if (state == ST_START) begin
                                        o_busy <= 1'b1;
                                    end
                                    if (state == ST_STOP) begin
                                        o_busy <= 1'b0;
                                    end
                                    if (state == ST_READ) begin
                                        o_rdata <= rx_shift;
                                    end
                                end else begin
                                    bit_cnt <= bit_cnt + 4'd1;
                                    phase   <= PH_A;
                                    sda_oen <= sda_phase_a(state, bit_cnt + 4'd1, tx_byte, ack_out_q);
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
module tb_i2c_master_ctrl;

    logic       i_sysclk = 1'b0;
    logic       i_reset_n = 1'b0;
    wire        scl_pin;
    wire        sda_pin;
    logic       i_cmd_valid = 1'b0;
    logic       o_cmd_ready;
    logic [2:0] i_cmd = 3'd0;
    logic [7:0] i_wdata = 8'h00;
    logic       i_ack_out = 1'b1;
    logic [7:0] o_rdata;
    logic       o_rx_ack;
    logic       o_done;
    logic       o_err;
    logic       o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave / bus monitor state
    logic       slave_scl_low = 1'b0;
    logic       slave_sda_low;
    int         slave_mode = 0;       // 0 idle, 1 write+ACK, 2 read, 3 write+NACK
    logic [7:0] slave_byte = 8'h00;
    logic       stretch_en = 1'b0;
    int         stretch_cnt = 0;
    int         fall_cnt = 0;
    int         base = 0;
    int         idx;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    logic [8:0] bits_seen = 9'h000;
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;

    int dur;
    int s0;
    int p0;

    pullup (scl_pin);
    pullup (sda_pin);
    assign scl_pin = slave_scl_low ? 1'b0 : 1'bz;
    assign sda_pin = slave_sda_low ? 1'b0 : 1'bz;

    i2c_master_ctrl #(.CLK_DIV(4)) dut (
        .i_sysclk    (i_sysclk),
        .i_reset_n   (i_reset_n),
        .scl_pin     (scl_pin),
        .sda_pin     (sda_pin),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd       (i_cmd),
        .i_wdata     (i_wdata),
        .i_ack_out   (i_ack_out),
        .o_rdata     (o_rdata),
        .o_rx_ack    (o_rx_ack),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_busy      (o_busy)
    );

    always #5 i_sysclk = ~i_sysclk;

    // Slave SDA only changes with fall_cnt/base, i.e. while SCL is low.
    always_comb begin
        slave_sda_low = 1'b0;
        idx = fall_cnt - base;
        case (slave_mode)
            1: if (idx == 8) slave_sda_low = 1'b1;
            2: if (idx >= 0 && idx < 8) slave_sda_low = !slave_byte[3'(7 - idx)];
            default: slave_sda_low = 1'b0;
        endcase
    end

    // Bus monitor: bits on SCL rise, START/STOP events, clock-stretch injection.
    always @(negedge i_sysclk) begin
        if (stretch_cnt > 0) begin
            stretch_cnt = stretch_cnt - 1;
            if (stretch_cnt == 0) slave_scl_low = 1'b0;
        end
        if (scl_pin && !scl_p) bits_seen = {bits_seen[7:0], sda_pin};
        if (!scl_pin && scl_p) begin
            fall_cnt = fall_cnt + 1;
            // Fall at start of bit 2 phase D: hold through D and A (8 cycles)
            // plus 50 cycles of bit 3 phase B.
            if (stretch_en && (fall_cnt - base == 3)) begin
                stretch_cnt   = 58;
                slave_scl_low = 1'b1;
            end
        end
        if (scl_pin && scl_p && sda_p && !sda_pin) start_cnt = start_cnt + 1;
        if (scl_pin && scl_p && !sda_p && sda_pin) stop_cnt = stop_cnt + 1;
        scl_p = scl_pin;
        sda_p = sda_pin;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command; dur = cycles with o_cmd_ready low. Returns in the o_done cycle.
    task automatic do_cmd(input logic [2:0] c, input logic [7:0] wd, input logic ack,
                          input int smode, input logic [7:0] sbyte, output int d);
        @(negedge i_sysclk);
        base        = fall_cnt;
        slave_mode  = smode;
        slave_byte  = sbyte;
        i_cmd       = c;
        i_wdata     = wd;
        i_ack_out   = ack;
        i_cmd_valid = 1'b1;
        @(negedge i_sysclk);
        i_cmd_valid = 1'b0;
        d = 0;
        for (int k = 0; k < 1000 && !o_done; k++) begin
            if (!o_cmd_ready) d++;
            @(negedge i_sysclk);
        end
        chk("done_seen", 32'(o_done), 32'd1);
        chk("ready_in_done", 32'(o_cmd_ready), 32'd1);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ready", 32'(o_cmd_ready), 32'd1);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_rdata", 32'(o_rdata), 32'h00);
        chk("rst_rx_ack", 32'(o_rx_ack), 32'd1);
        chk("rst_scl_oen", 32'(dut.scl_oen), 32'd1);
        chk("rst_sda_oen", 32'(dut.sda_oen), 32'd1);
        @(negedge i_sysclk);
        i_reset_n = 1'b1;
        repeat (3) @(negedge i_sysclk);

        // 1: START, WRITE A0 (ACK), STOP
        s0 = start_cnt; p0 = stop_cnt;
        do_cmd(3'd1, 8'h00, 1'b1, 0, 8'h00, dur);
        chk("t1_start_dur", 32'(dur), 32'd18);
        chk("t1_start_busy", 32'(o_busy), 32'd1);
        chk("t1_start_err", 32'(o_err), 32'd0);
        chk("t1_start_cond", 32'(start_cnt - s0), 32'd1);
        @(negedge i_sysclk);
        chk("t1_done_pulse", 32'(o_done), 32'd0);
        do_cmd(3'd2, 8'hA0, 1'b1, 1, 8'h00, dur);
        chk("t1_wr_dur", 32'(dur), 32'd162);
        chk("t1_wr_bits", 32'(bits_seen), 32'h140);
        chk("t1_wr_rx_ack", 32'(o_rx_ack), 32'd0);
        chk("t1_wr_no_sda_hi_chg", 32'(start_cnt - s0 + stop_cnt - p0), 32'd1);
        do_cmd(3'd4, 8'h00, 1'b1, 0, 8'h00, dur);
        chk("t1_stop_dur", 32'(dur), 32'd18);
        chk("t1_stop_busy", 32'(o_busy), 32'd0);
        chk("t1_stop_cond", 32'(stop_cnt - p0), 32'd1);

        // 2: START, WRITE A1, READ with NACK (slave sends 7E), STOP
        do_cmd(3'd1, 8'h00, 1'b1, 0, 8'h00, dur);
        do_cmd(3'd2, 8'hA1, 1'b1, 1, 8'h00, dur);
        chk("t2_wr_rx_ack", 32'(o_rx_ack), 32'd0);
        do_cmd(3'd3, 8'h00, 1'b1, 2, 8'h7E, dur);
        chk("t2_rd_dur", 32'(dur), 32'd162);
        chk("t2_rd_rdata", 32'(o_rdata), 32'h7E);
        chk("t2_rd_bus_bits", 32'(bits_seen), 32'h0FD);
        chk("t2_rd_err", 32'(o_err), 32'd0);
        p0 = stop_cnt;
        do_cmd(3'd4, 8'h00, 1'b1, 0, 8'h00, dur);
        chk("t2_stop_busy", 32'(o_busy), 32'd0);
        chk("t2_stop_cond", 32'(stop_cnt - p0), 32'd1);

        // 3: absent address, repeated START, stretched WRITE
        do_cmd(3'd1, 8'h00, 1'b1, 0, 8'h00, dur);
        do_cmd(3'd2, 8'h42, 1'b1, 3, 8'h00, dur);
        chk("t3_nack_rx_ack", 32'(o_rx_ack), 32'd1);
        chk("t3_nack_bits", 32'(bits_seen), 32'h085);
        s0 = start_cnt; p0 = stop_cnt;
        do_cmd(3'd1, 8'h00, 1'b1, 0, 8'h00, dur);
        chk("t3_rs_dur", 32'(dur), 32'd18);
        chk("t3_rs_busy", 32'(o_busy), 32'd1);
        chk("t3_rs_start", 32'(start_cnt - s0), 32'd1);
        chk("t3_rs_no_stop", 32'(stop_cnt - p0), 32'd0);
        chk("t3_rs_sda_hi_at_scl_rise", 32'(bits_seen[0]), 32'd1);
        stretch_en = 1'b1;
        do_cmd(3'd2, 8'h5C, 1'b1, 1, 8'h00, dur);
        stretch_en = 1'b0;
        chk("t4_stretch_dur", 32'(dur), 32'd212);
        chk("t4_stretch_bits", 32'(bits_seen), 32'h0B8);
        chk("t4_stretch_rx_ack", 32'(o_rx_ack), 32'd0);
        do_cmd(3'd4, 8'h00, 1'b1, 0, 8'h00, dur);
        chk("t4_stop_busy", 32'(o_busy), 32'd0);

        // 5: illegal commands while idle
        do_cmd(3'd2, 8'hFF, 1'b1, 0, 8'h00, dur);
        chk("t5_wr_dur", 32'(dur), 32'd0);
        chk("t5_wr_err", 32'(o_err), 32'd1);
        chk("t5_wr_busy", 32'(o_busy), 32'd0);
        chk("t5_wr_rdata", 32'(o_rdata), 32'h7E);
        chk("t5_wr_pads", 32'({scl_pin, sda_pin}), 32'd3);
        do_cmd(3'd7, 8'h00, 1'b1, 0, 8'h00, dur);
        chk("t5_bad_dur", 32'(dur), 32'd0);
        chk("t5_bad_err", 32'(o_err), 32'd1);
        chk("t5_bad_rdata", 32'(o_rdata), 32'h7E);
        chk("t5_bad_pads", 32'({scl_pin, sda_pin}), 32'd3);

        // 6: reset during READ bit 4
        do_cmd(3'd1, 8'h00, 1'b1, 0, 8'h00, dur);
        do_cmd(3'd2, 8'hA1, 1'b1, 1, 8'h00, dur);
        @(negedge i_sysclk);
        base        = fall_cnt;
        slave_mode  = 2;
        slave_byte  = 8'h3C;
        i_cmd       = 3'd3;
        i_ack_out   = 1'b0;
        i_cmd_valid = 1'b1;
        @(negedge i_sysclk);
        i_cmd_valid = 1'b0;
        repeat (75) @(negedge i_sysclk);
        #1 i_reset_n = 1'b0;
        #1;
        chk("t6_scl_oen", 32'(dut.scl_oen), 32'd1);
        chk("t6_sda_oen", 32'(dut.sda_oen), 32'd1);
        chk("t6_busy", 32'(o_busy), 32'd0);
        chk("t6_ready", 32'(o_cmd_ready), 32'd1);
        chk("t6_done", 32'(o_done), 32'd0);
        chk("t6_rdata", 32'(o_rdata), 32'h00);
        chk("t6_rx_ack", 32'(o_rx_ack), 32'd1);
        slave_mode = 0;
        #1;
        chk("t6_pads", 32'({scl_pin, sda_pin}), 32'd3);
        @(negedge i_sysclk);
        i_reset_n = 1'b1;
        repeat (2) @(negedge i_sysclk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
